// File: rtl/ssd_score_scanner_if.sv
// rtl/ssd_score_scanner_if.sv - load/status bus between the game core and the display scanner
interface ssd_score_scanner_if #(
  parameter int BIN_WIDTH = 14
);
  logic [BIN_WIDTH-1:0] value;
  logic                 load;
  logic                 hex_mode;
  logic                 busy;
  logic                 overflow;

  modport master (
    output value,
    output load,
    output hex_mode,
    input  busy,
    input  overflow
  );

  modport slave (
    input  value,
    input  load,
    input  hex_mode,
    output busy,
    output overflow
  );
endinterface

// File: rtl/ssd_score_scanner.sv
// rtl/ssd_score_scanner.sv - BCD/hex seven-segment scan driver with blanking and overflow dashes
module ssd_score_scanner #(
  parameter int NUM_DIGITS    = 4,
  parameter int SCAN_DIV_BITS = 18,
  parameter int BIN_WIDTH     = 14,
  parameter bit LZ_BLANK      = 1'b1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  ssd_score_scanner_if.slave    io_bus,
  input  logic [NUM_DIGITS-1:0] i_digit_en,
  input  logic [NUM_DIGITS-1:0] i_dp_mask,
  output logic [NUM_DIGITS-1:0] o_an,
  output logic [7:0]            o_cathodes
);

  localparam int DW    = 4 * NUM_DIGITS;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = $clog2(BIN_WIDTH + 1);
  localparam logic [32:0] MAX_DEC = 33'(10 ** NUM_DIGITS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_t;

  state_t                 r_state;
  state_t                 w_state_next;

  logic [SCAN_DIV_BITS-1:0] r_presc;
  logic [IDX_W-1:0]       r_idx;
  logic [DW-1:0]          r_disp;
  logic [DW-1:0]          r_bcd;
  logic [DW-1:0]          w_bcd_adj;
  logic [BIN_WIDTH-1:0]   r_bin;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_hex;
  logic                   r_ovf;
  logic                   r_hex_pend;
  logic [BIN_WIDTH-1:0]   r_hex_val;
  logic                   w_load_dec;
  logic                   w_load_hex;
  logic [NUM_DIGITS-1:0]  w_blank;
  logic [NUM_DIGITS-1:0]  w_an_next;
  logic                   w_upper_zero;
  logic [3:0]             w_nib;
  logic [6:0]             w_seg;
  logic [NUM_DIGITS-1:0]  r_an;
  logic [7:0]             r_cath;

  // Loads are only accepted while idle; a load during a conversion is dropped.
  assign w_load_dec = (r_state == ST_IDLE) & io_bus.load & ~io_bus.hex_mode;
  assign w_load_hex = (r_state == ST_IDLE) & io_bus.load & io_bus.hex_mode;

  assign io_bus.busy     = (r_state != ST_IDLE);
  assign io_bus.overflow = r_ovf;
  assign o_an            = r_an;
  assign o_cathodes      = r_cath;

  // Free-running prescaler; digit index steps once per prescaler wrap.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_presc <= '0;
      r_idx   <= '0;
    end else begin
      r_presc <= r_presc + 1'b1;
      if (&r_presc) begin
        r_idx <= (r_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : r_idx + 1'b1;
      end
    end
  end

  // Conversion FSM state register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Conversion FSM next-state: SHIFT runs once per input bit, DONE commits.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_load_dec) w_state_next = ST_SHIFT;
      ST_SHIFT: if (r_cnt == CNT_W'(1)) w_state_next = ST_DONE;
      ST_DONE:  w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  // Double-dabble correction: bump every BCD nibble of 5 or more by 3 before the shift.
  always_comb begin
    w_bcd_adj = r_bcd;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) begin
        w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
      end
    end
  end

  // Datapath: capture, shift, commit; hex writes land one edge after the load is sampled.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_bin      <= '0;
      r_bcd      <= '0;
      r_cnt      <= '0;
      r_disp     <= '0;
      r_hex      <= 1'b0;
      r_ovf      <= 1'b0;
      r_hex_pend <= 1'b0;
      r_hex_val  <= '0;
    end else begin
      r_hex_pend <= w_load_hex;
      if (w_load_hex) begin
        r_hex_val <= io_bus.value;
      end
      if (r_hex_pend) begin
        r_disp <= DW'(r_hex_val);
        r_hex  <= 1'b1;
        r_ovf  <= 1'b0;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_load_dec) begin
            r_bin <= io_bus.value;
            r_bcd <= '0;
            r_cnt <= CNT_W'(BIN_WIDTH);
            r_ovf <= (33'(io_bus.value) > MAX_DEC);
          end
        end
        ST_SHIFT: begin
          {r_bcd, r_bin} <= {w_bcd_adj, r_bin} << 1;
          r_cnt          <= r_cnt - 1'b1;
        end
        ST_DONE: begin
          r_disp <= r_bcd;
          r_hex  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Leading-zero blanking: a digit blanks when it and every digit above it are zero.
  always_comb begin
    w_blank      = '0;
    w_upper_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      w_upper_zero = w_upper_zero & (r_disp[4*i +: 4] == 4'd0);
      w_blank[i]   = LZ_BLANK & ~r_hex & ~r_ovf & (i != 0) & w_upper_zero;
    end
  end

  // Anode select: only the indexed, enabled, unblanked digit is driven low.
  always_comb begin
    w_an_next = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      w_an_next[i] = ~((IDX_W'(i) == r_idx) & i_digit_en[i] & ~w_blank[i]);
    end
  end

  // Segment decode of the indexed nibble, replaced by a dash on overflow.
  always_comb begin
    w_nib = r_disp[{r_idx, 2'b00} +: 4];
    w_seg = 7'b1111111;
    case (w_nib)
      4'h0: w_seg = 7'b0000001;
      4'h1: w_seg = 7'b1001111;
      4'h2: w_seg = 7'b0010010;
      4'h3: w_seg = 7'b0000110;
      4'h4: w_seg = 7'b1001100;
      4'h5: w_seg = 7'b0100100;
      4'h6: w_seg = 7'b0100000;
      4'h7: w_seg = 7'b0001111;
      4'h8: w_seg = 7'b0000000;
      4'h9: w_seg = 7'b0000100;
      4'hA: w_seg = 7'b0001000;
      4'hB: w_seg = 7'b1100000;
      4'hC: w_seg = 7'b0110001;
      4'hD: w_seg = 7'b1000010;
      4'hE: w_seg = 7'b0110000;
      4'hF: w_seg = 7'b0111000;
      default: w_seg = 7'b1111111;
    endcase
    if (r_ovf) begin
      w_seg = 7'b1111110;
    end
  end

  // Registered pin drivers so anodes and cathodes switch together.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_an   <= '1;
      r_cath <= 8'hFF;
    end else begin
      r_an   <= w_an_next;
      r_cath <= {w_seg, ~i_dp_mask[r_idx]};
    end
  end

endmodule

// File: tb/tb_ssd_score_scanner.sv
// tb/tb_ssd_score_scanner.sv - directed scoreboard bench for the seven-segment scanner
module tb_ssd_score_scanner;

  logic       clk;
  logic       rst;
  logic [3:0] en;
  logic [3:0] dp;
  logic [3:0] an_a;
  logic [3:0] an_b;
  logic [7:0] ca_a;
  logic [7:0] ca_b;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0] an;
    logic [7:0] cath;
  } exp_t;

  exp_t exp_q[$];
  exp_t done_q[$];

  ssd_score_scanner_if #(.BIN_WIDTH(14)) bus_a ();
  ssd_score_scanner_if #(.BIN_WIDTH(14)) bus_b ();

  assign bus_b.value    = bus_a.value;
  assign bus_b.load     = bus_a.load;
  assign bus_b.hex_mode = bus_a.hex_mode;

  ssd_score_scanner #(
    .NUM_DIGITS(4), .SCAN_DIV_BITS(2), .BIN_WIDTH(14), .LZ_BLANK(1'b1)
  ) dut_a (
    .i_clk(clk), .i_rst(rst), .io_bus(bus_a),
    .i_digit_en(en), .i_dp_mask(dp), .o_an(an_a), .o_cathodes(ca_a)
  );

  ssd_score_scanner #(
    .NUM_DIGITS(4), .SCAN_DIV_BITS(2), .BIN_WIDTH(14), .LZ_BLANK(1'b0)
  ) dut_b (
    .i_clk(clk), .i_rst(rst), .io_bus(bus_b),
    .i_digit_en(en), .i_dp_mask(dp), .o_an(an_b), .o_cathodes(ca_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [3:0] a, input logic [7:0] c);
    exp_t e;
    e.an   = a;
    e.cath = c;
    exp_q.push_back(e);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Watch a full scan period; every lit anode must match a queued digit.
  task automatic scan_check(input bit sel, input string tag);
    logic [3:0] a;
    logic [7:0] c;
    int idx;
    done_q.delete();
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(posedge clk);
      #1;
      a = sel ? an_b : an_a;
      c = sel ? ca_b : ca_a;
      if (a != 4'hF) begin
        idx = -1;
        for (int k = 0; k < exp_q.size(); k++) begin
          if (idx < 0 && exp_q[k].an == a) idx = k;
        end
        if (idx >= 0) begin
          chk({tag, "_seg"}, {24'd0, c}, {24'd0, exp_q[idx].cath});
          done_q.push_back(exp_q[idx]);
          exp_q.delete(idx);
        end else begin
          for (int k = 0; k < done_q.size(); k++) begin
            if (idx < 0 && done_q[k].an == a) idx = k;
          end
          if (idx >= 0) begin
            chk({tag, "_seg"}, {24'd0, c}, {24'd0, done_q[idx].cath});
          end else begin
            chk({tag, "_stray_anode"}, {28'd0, a}, 32'hF);
          end
        end
      end
    end
    chk({tag, "_missing_digits"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic do_load(input logic [13:0] v, input logic h);
    bus_a.value    = v;
    bus_a.hex_mode = h;
    bus_a.load     = 1'b1;
    @(posedge clk);
    #1;
    bus_a.load     = 1'b0;
  endtask

  // Decimal load; counts Busy-high cycles with a bounded wait.
  task automatic load_dec(input logic [13:0] v, input string tag);
    int n;
    int guard;
    do_load(v, 1'b0);
    n = bus_a.busy ? 1 : 0;
    guard = 0;
    while (bus_a.busy && guard < 40) begin
      @(posedge clk);
      #1;
      guard++;
      if (bus_a.busy) n++;
    end
    chk({tag, "_busy_cycles"}, n, 15);
  endtask

  initial begin
    rst            = 1'b1;
    en             = 4'hF;
    dp             = 4'h0;
    bus_a.value    = '0;
    bus_a.load     = 1'b0;
    bus_a.hex_mode = 1'b0;
    #12;
    chk("reset_an", {28'd0, an_a}, 32'hF);
    chk("reset_cath", {24'd0, ca_a}, 32'hFF);
    chk("reset_busy", {31'd0, bus_a.busy}, 0);
    chk("reset_ovf", {31'd0, bus_a.overflow}, 0);
    @(negedge clk);
    rst = 1'b0;
    cycles(3);

    // Decimal 1234
    load_dec(14'd1234, "d1234");
    chk("d1234_ovf", {31'd0, bus_a.overflow}, 0);
    cycles(2);
    push_exp(4'b1110, 8'b10011001);
    push_exp(4'b1101, 8'b00001101);
    push_exp(4'b1011, 8'b00100101);
    push_exp(4'b0111, 8'b10011111);
    scan_check(1'b0, "d1234_a");

    // Decimal 7: blanked on A, zero-padded on B
    load_dec(14'd7, "d7");
    cycles(2);
    push_exp(4'b1110, 8'b00011111);
    scan_check(1'b0, "d7_lz");
    push_exp(4'b1110, 8'b00011111);
    push_exp(4'b1101, 8'b00000011);
    push_exp(4'b1011, 8'b00000011);
    push_exp(4'b0111, 8'b00000011);
    scan_check(1'b1, "d7_nolz");

    // Overflow
    load_dec(14'd12000, "d12000");
    chk("d12000_ovf", {31'd0, bus_a.overflow}, 1);
    cycles(2);
    push_exp(4'b1110, 8'b11111101);
    push_exp(4'b1101, 8'b11111101);
    push_exp(4'b1011, 8'b11111101);
    push_exp(4'b0111, 8'b11111101);
    scan_check(1'b0, "ovf_all");
    en = 4'b1011;
    cycles(2);
    push_exp(4'b1110, 8'b11111101);
    push_exp(4'b1101, 8'b11111101);
    push_exp(4'b0111, 8'b11111101);
    scan_check(1'b0, "ovf_en");
    en = 4'hF;

    // Hex 2BEF
    do_load(14'h2BEF, 1'b1);
    chk("hex_busy0", {31'd0, bus_a.busy}, 0);
    cycles(3);
    chk("hex_busy1", {31'd0, bus_a.busy}, 0);
    chk("hex_ovf", {31'd0, bus_a.overflow}, 0);
    push_exp(4'b1110, 8'b01110001);
    push_exp(4'b1101, 8'b01100001);
    push_exp(4'b1011, 8'b11000001);
    push_exp(4'b0111, 8'b00100101);
    scan_check(1'b0, "hex");
    dp = 4'b0010;
    cycles(2);
    push_exp(4'b1110, 8'b01110001);
    push_exp(4'b1101, 8'b01100000);
    push_exp(4'b1011, 8'b11000001);
    push_exp(4'b0111, 8'b00100101);
    scan_check(1'b0, "hex_dp");
    dp = 4'h0;

    // Load while busy is ignored
    do_load(14'd1234, 1'b0);
    cycles(1);
    do_load(14'd9999, 1'b0);
    chk("busy_ignore", {31'd0, bus_a.busy}, 1);
    begin
      int guard = 0;
      while (bus_a.busy && guard < 40) begin
        @(posedge clk);
        #1;
        guard++;
      end
      chk("busy_ignore_done", {31'd0, bus_a.busy}, 0);
    end
    cycles(2);
    push_exp(4'b1110, 8'b10011001);
    push_exp(4'b1101, 8'b00001101);
    push_exp(4'b1011, 8'b00100101);
    push_exp(4'b0111, 8'b10011111);
    scan_check(1'b0, "ignore_9999");

    // Asynchronous reset in the middle of a conversion
    do_load(14'd5678, 1'b0);
    cycles(4);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_an", {28'd0, an_a}, 32'hF);
    chk("midrst_cath", {24'd0, ca_a}, 32'hFF);
    chk("midrst_busy", {31'd0, bus_a.busy}, 0);
    @(negedge clk);
    rst = 1'b0;
    cycles(2);
    push_exp(4'b1110, 8'b00000011);
    scan_check(1'b0, "midrst_lz");
    push_exp(4'b1110, 8'b00000011);
    push_exp(4'b1101, 8'b00000011);
    push_exp(4'b1011, 8'b00000011);
    push_exp(4'b0111, 8'b00000011);
    scan_check(1'b1, "midrst_nolz");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ssd_score_scanner.md
# ssd_score_scanner

Parametrised seven-segment display driver replacing the fixed two-digit hex scan in the board top level. Takes a binary value (game score or debug word), converts it to BCD with a sequential double-dabble engine, or passes it through raw in hex mode. Time-multiplexes the result across NUM_DIGITS active-low anodes with leading-zero blanking, per-digit enables, decimal points and overflow indication. Sits between the game core and the board's An/Ca..Cg/Dp pins, clocked by the undivided board clock.

## Interface

- NUM_DIGITS, 4: number of digits and anodes (1..8).
- SCAN_DIV_BITS, 18: prescaler width; digit advances every 2^SCAN_DIV_BITS clocks (381 Hz at 100 MHz).
- BIN_WIDTH, 14: width of Value (at most 4*NUM_DIGITS).
- LZ_BLANK, 1: enables leading-zero blanking in decimal mode.

- Clk  in  1  board clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- Value  in  BIN_WIDTH  binary value to display.
- Load  in  1  single-cycle request to capture Value.
- Hex_Mode  in  1  sampled with Load; 1 = raw hex nibbles, 0 = decimal.
- Digit_En  in  NUM_DIGITS  per-digit enable; 0 keeps that anode off.
- Dp_Mask  in  NUM_DIGITS  1 = light decimal point of that digit.
- Busy  out  1  conversion in progress.
- Overflow  out  1  last decimal load exceeded 10^NUM_DIGITS-1.
- An  out  NUM_DIGITS  active-low anodes; An[0] is the rightmost digit.
- Cathodes  out  8  active-low {Ca,Cb,Cc,Cd,Ce,Cf,Cg,Dp}.

## Operation

- Reset: prescaler=0, digit index=0, display register=0, Busy=0, Overflow=0, An=all ones, Cathodes=8'hFF. Takes effect immediately, regardless of clock.
- Prescaler: free-running SCAN_DIV_BITS counter. On the cycle it is all ones, the digit index advances by 1, wrapping NUM_DIGITS-1 -> 0.
- Conversion FSM, states IDLE / SHIFT / DONE:
  - IDLE, Load=1, Hex_Mode=0: capture Value into the shift register, clear BCD, set Overflow = (Value > 10^NUM_DIGITS-1), counter=BIN_WIDTH, Busy=1, go to SHIFT.
  - IDLE, Load=1, Hex_Mode=1: next edge writes Value, zero-extended to 4*NUM_DIGITS, into the display register. Overflow=0, hex flag set, Busy stays 0, stay in IDLE.
  - SHIFT: each cycle, add 3 to every BCD nibble >=5, then shift {BCD,bin} left by 1 and decrement the counter. When the counter reaches 0, go to DONE.
  - DONE: copy BCD to the display register as one atomic write, clear the hex flag, Busy=0, go to IDLE.
- Load while Busy=1 is ignored and not queued.
- Reset during SHIFT aborts the conversion and clears the display register to 0.
- Per digit i at the current index:
  - blank_i = LZ_BLANK & ~hex flag & (i != 0) & all nibbles i..NUM_DIGITS-1 are zero.
  - An[i] = 0 only when i == index, Digit_En[i]=1 and blank_i=0. All other anodes are 1.
- Segment decode, abcdefg, active low:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, B=1100000, C=0110001, D=1000010, E=0110000, F=0111000
- Overflow=1: every enabled digit shows a dash (1111110), with no blanking.
- Dp = ~Dp_Mask[index], independent of blanking.

## Timing

- An and Cathodes are registered. They reflect the index and display register of the previous cycle (1-cycle latency).
- Decimal load: Busy rises on the edge that samples Load. It stays high for BIN_WIDTH+1 cycles. The display register and Overflow are valid on the edge where Busy falls.
- Hex load: the display register is updated on the edge after the one that samples Load.
- A prescaler wrap in the same cycle as a Load or DONE: both take effect; they are independent.
- A Digit_En or Dp_Mask change is visible on pins 1 cycle later.

## Test plan

Bench uses NUM_DIGITS=4, SCAN_DIV_BITS=2, BIN_WIDTH=14.

- Reset asserted mid-run -> An=4'b1111, Cathodes=8'hFF, Busy=0 immediately, without waiting for an edge.
- Load Value=1234, Hex_Mode=0 -> Busy high for 15 cycles. Scan then shows An=1110 with 4 (10011001), 1101 with 3, 1011 with 2, 0111 with 1.
- Load Value=7 -> only An[0] ever goes low, showing 00011111. Digits 1..3 stay blank. Repeat with LZ_BLANK=0 -> 0,0,0,7 shown.
- Load Value=12000 -> Overflow=1, all four digits show 11111101. Disabling Digit_En[2] keeps An[2]=1.
- Hex_Mode=1, Value=14'h2BEF -> Busy stays 0, digits show F,E,B,2. Dp_Mask=4'b0010 -> Dp=0 only while An[1]=0.
- Load 1234, then Load 9999 two cycles later -> the second Load is ignored and 1234 is displayed. Reset during SHIFT -> display 0, Busy=0.
